seq_detect_ctrl: RTL

Programmable serial pattern-detection controller. It holds a run-time pattern configuration and frames detection runs with a start/busy/done handshake. During a run it matches the pattern against a valid-qualified serial bit stream, producing per-match pulses and a saturating match count. It sits between the control/register side and the serial input, replacing the fixed-pattern detectors wherever the pattern, length or overlap policy must change at run time.

---
 rtl/seq_detect_ctrl_if.sv | 33 +++
 rtl/seq_detect_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - control, configuration and serial-stream bundle for seq_detect_ctrl
//
// master: drives configuration writes, run requests and the serial stream; observes status.
// slave : the detector; consumes the requests and stream, drives busy/done/match/match_count/error.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               start;
    logic [CNT_W-1:0]   frame_len;
    logic               in;
    logic               in_valid;
    logic               busy;
    logic               done;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               error;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len, in, in_valid,
        input  busy, done, match, match_count, error
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, frame_len, in, in_valid,
        output busy, done, match, match_count, error
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with start/busy/done run framing
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - seq_detect_ctrl_if.slave: cfg_we/cfg_pattern/cfg_len/cfg_overlap configuration write,
//           start/frame_len run request, in/in_valid serial stream,
//           busy/done/match/match_count/error registered status outputs
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic           clk,
    input logic           reset,
    seq_detect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   frame_len_q, frame_len_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic               match_q, match_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic               cfg_ok;

    // Low len_q bits set: selects the live part of history and pattern.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Match is judged on the history as it will be after accepting the current bit.
    assign hist_nxt = {hist_q[MAX_LEN-2:0], bus.in};
    assign fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    assign hit      = (fill_inc >= len_q) && (((hist_nxt ^ pattern_q) & len_mask) == '0);
    assign cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);

    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        overlap_d     = overlap_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        bit_cnt_d     = bit_cnt_q;
        frame_len_d   = frame_len_q;
        match_count_d = match_count_q;
        match_d       = 1'b0;
        error_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cfg_we) begin
                    if (cfg_ok) begin
                        pattern_d = bus.cfg_pattern;
                        len_d     = bus.cfg_len;
                        overlap_d = bus.cfg_overlap;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                if (bus.start && (bus.frame_len != '0)) begin
                    hist_d        = '0;
                    fill_d        = '0;
                    bit_cnt_d     = '0;
                    match_count_d = '0;
                    frame_len_d   = bus.frame_len;
                    state_d       = RUN;
                end
            end
            RUN: begin
                error_d = bus.cfg_we;
                if (bus.in_valid) begin
                    hist_d    = hist_nxt;
                    fill_d    = fill_inc;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (hit) begin
                        match_d = 1'b1;
                        if (match_count_q != CNT_MAX) begin
                            match_count_d = match_count_q + CNT_W'(1);
                        end
                        // Non-overlapping: the matched bits may not seed the next match.
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                    end
                    if (bit_cnt_d == frame_len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                error_d = bus.cfg_we;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pattern_q     <= MAX_LEN'(4'b1101);
            len_q         <= LEN_W'(4);
            overlap_q     <= 1'b1;
            hist_q        <= '0;
            fill_q        <= '0;
            bit_cnt_q     <= '0;
            frame_len_q   <= '0;
            match_count_q <= '0;
            match_q       <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            overlap_q     <= overlap_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_len_q   <= frame_len_d;
            match_count_q <= match_count_d;
            match_q       <= match_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.match       = match_q;
    assign bus.match_count = match_count_q;
    assign bus.error       = error_q;
endmodule
